// File: rtl/c_hazard_pkg.sv
// Shared types and encodings for the F/D/E/W pipeline hazard controller.
package c_hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } hz_state_t;

    // Execute-path encodings, also used by the decoder and the ID/EX register.
    localparam logic [1:0] EXP_ALU  = 2'b00;
    localparam logic [1:0] EXP_MEM  = 2'b01;
    localparam logic [1:0] EXP_LINK = 2'b10;

    // Operand source selects. Codes 10 and 11 are reserved.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;

endpackage

// File: rtl/c_hazard_forward.sv
// W->E forwarding compare for a single E-stage source operand.
module c_hazard_forward
    import c_hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_w,
    input  logic       reg_we_w,
    output logic [1:0] fwd
);

    // x0 is hardwired to zero, so a write to it is never forwarded.
    always_comb begin
        fwd = FWD_RF;
        if (reg_we_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/c_hazard_unit.sv
// Pipeline hazard controller: stall/flush generation, W->E forwarding,
// data-memory wait sequencing with timeout, and a stall-cycle counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; branch flush and load-use bubble handled here
// MEM_WAIT | E-stage memory access outstanding; pipeline frozen
// FAULT    | memory never answered; pipeline frozen until reset
module c_hazard_unit
    import c_hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdW,
    input  logic             RegWE_W_E,
    input  logic             RegWE_W_W,
    input  logic [1:0]       ExPathE,
    input  logic             MemWriteE,
    input  logic             PCSrcE,
    input  logic             DMemReadyE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    // Last wait-counter value tolerated before the access is declared lost.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    hz_state_t  state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       mem_e;
    logic       load_use;
    logic       mem_stall;
    logic       eval_flow;
    logic [1:0] fwd_a, fwd_b;

    c_hazard_forward u_fwd_a (
        .rs_e     (Rs1E),
        .rd_w     (RdW),
        .reg_we_w (RegWE_W_W),
        .fwd      (fwd_a)
    );

    c_hazard_forward u_fwd_b (
        .rs_e     (Rs2E),
        .rd_w     (RdW),
        .reg_we_w (RegWE_W_W),
        .fwd      (fwd_b)
    );

    // Hazard qualifiers for the instructions currently in D and E.
    always_comb begin
        mem_e    = (ExPathE == EXP_MEM) || MemWriteE;
        load_use = (ExPathE == EXP_MEM) && RegWE_W_E && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // State register and wait counter; reset abandons any pending access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state and wait-counter sequencing; eval_flow marks cycles where
    // the branch/load-use rules may act because no memory stall is in force.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        eval_flow    = 1'b0;
        case (state)
            RUN: begin
                if (mem_e && !DMemReadyE) begin
                    mem_stall    = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else begin
                    eval_flow = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (DMemReadyE) begin
                    eval_flow    = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = FAULT;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
            end
            FAULT: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Mealy stall/flush/forward outputs, all forced quiet while in reset.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!reset) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushW = 1'b1;
            end else if (eval_flow && PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (eval_flow && load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Sticky fault flag, visible from the first cycle spent in FAULT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MemTimeout <= 1'b0;
        end else if (state_nxt == FAULT) begin
            MemTimeout <= 1'b1;
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
        end else if (StallF && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_c_hazard_unit.sv
// Bench for c_hazard_unit: a default instance (16-cycle timeout, 32-bit count)
// and a small instance (4-cycle timeout, 4-bit count) share the same stimulus.
module tb_c_hazard_unit;
    import c_hazard_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdW;
    logic       RegWE_W_E, RegWE_W_W, MemWriteE, PCSrcE, DMemReadyE;
    logic [1:0] ExPathE;

    logic       sf_a, sd_a, se_a, fd_a, fe_a, fw_a, mt_a;
    logic       sf_b, sd_b, se_b, fd_b, fe_b, fw_b, mt_b;
    logic [1:0] fa_a, fb_a, fa_b, fb_b;
    logic [31:0] sc_a;
    logic [3:0]  sc_b;

    logic [9:0]  ctl [2];
    logic        mt  [2];
    logic [31:0] sc  [2];

    int checks = 0;
    int errors = 0;

    // Reference model state: stalled cycles on the current access, fault flag, count.
    int              m_wait  [2];
    bit              m_fault [2];
    longint unsigned m_cnt   [2];
    int              tmo     [2] = '{16, 4};
    longint unsigned cnt_max [2] = '{64'hFFFF_FFFF, 64'd15};

    always #5 clk = ~clk;

    c_hazard_unit dut_a (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdW(RdW),
        .RegWE_W_E(RegWE_W_E), .RegWE_W_W(RegWE_W_W), .ExPathE(ExPathE),
        .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .DMemReadyE(DMemReadyE),
        .StallF(sf_a), .StallD(sd_a), .StallE(se_a),
        .FlushD(fd_a), .FlushE(fe_a), .FlushW(fw_a),
        .ForwardAE(fa_a), .ForwardBE(fb_a),
        .MemTimeout(mt_a), .StallCount(sc_a)
    );

    c_hazard_unit #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdW(RdW),
        .RegWE_W_E(RegWE_W_E), .RegWE_W_W(RegWE_W_W), .ExPathE(ExPathE),
        .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .DMemReadyE(DMemReadyE),
        .StallF(sf_b), .StallD(sd_b), .StallE(se_b),
        .FlushD(fd_b), .FlushE(fe_b), .FlushW(fw_b),
        .ForwardAE(fa_b), .ForwardBE(fb_b),
        .MemTimeout(mt_b), .StallCount(sc_b)
    );

    assign ctl[0] = {sf_a, sd_a, se_a, fd_a, fe_a, fw_a, fa_a, fb_a};
    assign ctl[1] = {sf_b, sd_b, se_b, fd_b, fe_b, fw_b, fa_b, fb_b};
    assign mt[0]  = mt_a;
    assign mt[1]  = mt_b;
    assign sc[0]  = sc_a;
    assign sc[1]  = {28'd0, sc_b};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1d, input logic [4:0] rs2d,
                          input logic [4:0] rs1e, input logic [4:0] rs2e,
                          input logic [4:0] rde, input logic [4:0] rdw,
                          input logic we_e, input logic we_w, input logic [1:0] path,
                          input logic mw, input logic pcs, input logic rdy);
        Rs1D = rs1d; Rs2D = rs2d; Rs1E = rs1e; Rs2E = rs2e; RdE = rde; RdW = rdw;
        RegWE_W_E = we_e; RegWE_W_W = we_w; ExPathE = path;
        MemWriteE = mw; PCSrcE = pcs; DMemReadyE = rdy;
    endtask

    // Called just after a falling edge with inputs applied: compares both DUTs
    // against the model, advances the model across the coming rising edge,
    // and returns at the next falling edge.
    task automatic step();
        logic [9:0] e;
        logic       mstall, mem_e, lu;
        #1;
        mem_e = (ExPathE == EXP_MEM) || MemWriteE;
        lu    = (ExPathE == EXP_MEM) && RegWE_W_E && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_fault[k] = 1'b0;
                m_wait[k]  = 0;
                m_cnt[k]   = 0;
            end
            e = '0;
            mstall = m_fault[k] || ((m_wait[k] > 0) ? !DMemReadyE : (mem_e && !DMemReadyE));
            if (!reset) begin
                e[3:2] = (RegWE_W_W && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
                e[1:0] = (RegWE_W_W && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
                if (mstall)      e[9:4] = 6'b111_001;
                else if (PCSrcE) e[9:4] = 6'b000_110;
                else if (lu)     e[9:4] = 6'b110_010;
            end
            chk($sformatf("ctl[%0d]", k), ctl[k], e);
            chk($sformatf("MemTimeout[%0d]", k), mt[k], m_fault[k]);
            chk($sformatf("StallCount[%0d]", k), sc[k], m_cnt[k]);
            if (!reset) begin
                if (e[9]) m_cnt[k] = (m_cnt[k] == cnt_max[k]) ? cnt_max[k] : m_cnt[k] + 1;
                if (!m_fault[k]) begin
                    if (mstall) begin
                        m_wait[k]++;
                        if (m_wait[k] == tmo[k]) m_fault[k] = 1'b1;
                    end else begin
                        m_wait[k] = 0;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, EXP_ALU, 0, 0, 1);
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdw;
        logic       we_e, we_w;
        logic [1:0] path;
        logic       mw, pcs;
        logic [9:0] ectl;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, EXP_ALU,  1'b0, 1'b0, 10'b000_000_00_00};
        vecs[1]  = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd5, 5'd0, 1'b1, 1'b0, EXP_MEM,  1'b0, 1'b0, 10'b110_010_00_00};
        vecs[2]  = '{5'd1, 5'd7, 5'd2, 5'd3, 5'd7, 5'd0, 1'b1, 1'b0, EXP_MEM,  1'b0, 1'b0, 10'b110_010_00_00};
        vecs[3]  = '{5'd4, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, EXP_MEM,  1'b0, 1'b0, 10'b000_000_00_00};
        vecs[4]  = '{5'd1, 5'd2, 5'd5, 5'd6, 5'd8, 5'd5, 1'b0, 1'b1, EXP_ALU,  1'b0, 1'b0, 10'b000_000_01_00};
        vecs[5]  = '{5'd1, 5'd2, 5'd6, 5'd9, 5'd8, 5'd9, 1'b0, 1'b1, EXP_ALU,  1'b0, 1'b0, 10'b000_000_00_01};
        vecs[6]  = '{5'd1, 5'd2, 5'd9, 5'd9, 5'd8, 5'd9, 1'b0, 1'b1, EXP_ALU,  1'b0, 1'b0, 10'b000_000_01_01};
        vecs[7]  = '{5'd3, 5'd2, 5'd1, 5'd1, 5'd3, 5'd0, 1'b1, 1'b0, EXP_MEM,  1'b0, 1'b1, 10'b000_110_00_00};
        vecs[8]  = '{5'd3, 5'd2, 5'd1, 5'd1, 5'd3, 5'd0, 1'b0, 1'b0, EXP_MEM,  1'b0, 1'b0, 10'b000_000_00_00};
        vecs[9]  = '{5'd4, 5'd2, 5'd1, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0, EXP_ALU,  1'b0, 1'b0, 10'b000_000_00_00};
        vecs[10] = '{5'd4, 5'd2, 5'd5, 5'd1, 5'd4, 5'd5, 1'b1, 1'b0, EXP_ALU,  1'b1, 1'b0, 10'b000_000_00_00};
        vecs[11] = '{5'd4, 5'd2, 5'd5, 5'd1, 5'd4, 5'd5, 1'b1, 1'b1, EXP_LINK, 1'b0, 1'b0, 10'b000_000_01_00};

        // Reset with hazard-provoking inputs: everything must stay quiet.
        reset = 1'b1;
        set_in(5, 5, 5, 5, 5, 5, 1, 1, EXP_MEM, 1, 1, 0);
        @(negedge clk);
        #1;
        chk("reset ctl", ctl[0], 10'd0);
        chk("reset StallCount", sc[0], 32'd0);
        chk("reset MemTimeout", mt[0], 1'b0);
        step();
        reset = 1'b0;

        // Single-cycle vectors from RUN with memory always ready.
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].rs1d, vecs[i].rs2d, vecs[i].rs1e, vecs[i].rs2e, vecs[i].rde,
                   vecs[i].rdw, vecs[i].we_e, vecs[i].we_w, vecs[i].path,
                   vecs[i].mw, vecs[i].pcs, 1'b1);
            #1;
            chk($sformatf("vec %0d", i), ctl[0], vecs[i].ectl);
            step();
        end

        // Load-use bubble, then the dependent instruction forwards from W.
        do_reset();
        set_in(5, 0, 0, 0, 5, 0, 1, 0, EXP_MEM, 0, 0, 1);
        #1;
        chk("loaduse bubble", ctl[0], 10'b110_010_00_00);
        step();
        set_in(0, 0, 5, 0, 0, 5, 0, 1, EXP_ALU, 0, 0, 1);
        #1;
        chk("loaduse forward", ctl[0], 10'b000_000_01_00);
        step();

        // Memory wait: three not-ready cycles, released on the fourth.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, EXP_MEM, 0, 0, 0);
            #1;
            chk("memwait stall", {sf_a, sd_a, se_a, fw_a}, 4'b1111);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, EXP_MEM, 0, 0, 1);
        #1;
        chk("memwait release", ctl[0], 10'd0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, EXP_ALU, 0, 0, 0);
        #1;
        chk("memwait count", sc[0], 32'd3);
        chk("memwait count small", sc[1], 32'd3);
        step();

        // Timeout on the small instance, then saturation of its 4-bit counter.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, EXP_ALU, 1, 0, 0);
            step();
        end
        #1;
        chk("timeout flag", mt[1], 1'b1);
        chk("no timeout default", mt[0], 1'b0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, EXP_ALU, 0, 0, 1);
        #1;
        chk("fault ignores ready", sf_b, 1'b1);
        chk("default released", sf_a, 1'b0);
        step();
        for (int i = 0; i < 20; i++) step();
        #1;
        chk("saturated count", sc[1], 32'd15);
        chk("fault sticky", mt[1], 1'b1);
        reset = 1'b1;
        #1;
        chk("fault reset ctl", ctl[1], 10'd0);
        chk("fault reset flag", mt[1], 1'b0);
        step();
        reset = 1'b0;

        // Asynchronous reset in the middle of a memory wait.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, EXP_MEM, 0, 0, 0);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("async reset ctl", ctl[0], 10'd0);
        step();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, EXP_ALU, 0, 0, 0);
        #1;
        chk("after reset run", sf_a, 1'b0);
        step();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 6));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c_hazard_unit.md
Name: c_hazard_unit

Overview:
- Pipeline hazard controller for the F/D/E/W core.
- Produces the stall and flush controls consumed by the IF/ID, ID/EX and EX/WB pipeline registers: StallF, StallD, StallE, FlushD, FlushE, FlushW.
- Produces the W->E operand forwarding selects.
- Sequences multi-cycle data-memory waits through a small FSM with a timeout watchdog and a saturating stall-cycle performance counter.

Parameters:
TIMEOUT_CYCLES, 16, MEM_WAIT cycles allowed before declaring a memory fault (range 2..255)
CNT_W, 32, width of StallCount

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
Rs1D  in  5  source register 1 of the instruction in D
Rs2D  in  5  source register 2 of the instruction in D
Rs1E  in  5  source register 1 of the instruction in E
Rs2E  in  5  source register 2 of the instruction in E
RdE  in  5  destination register of the instruction in E
RdW  in  5  destination register of the instruction in W
RegWE_W_E  in  1  instruction in E writes the register file in W
RegWE_W_W  in  1  instruction in W writes the register file
ExPathE  in  2  execute path of the instruction in E
MemWriteE  in  1  instruction in E is a store
PCSrcE  in  1  taken branch or jump resolved in E
DMemReadyE  in  1  data memory completes the E-stage access this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register to NOP
FlushW  out  1  clear EX/WB register to NOP
ForwardAE  out  2  operand A source: 00 regfile, 01 W result
ForwardBE  out  2  operand B source: 00 regfile, 01 W result
MemTimeout  out  1  sticky memory fault flag
StallCount  out  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Reset: asynchronous, active-high. While reset=1 and after it:
  - state=RUN, wait counter=0, MemTimeout=0, StallCount=0.
  - All Stall*/Flush* outputs are 0 and ForwardAE/ForwardBE are 00 while reset=1.
- Definitions:
  - memE = (ExPathE==EXP_MEM) | MemWriteE.
  - loaduse = ExPathE==EXP_MEM & RegWE_W_E & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Outputs are Mealy: combinational from state plus current inputs. Only the state, wait counter, MemTimeout and StallCount are registered.
- FSM states: RUN, MEM_WAIT, FAULT.
- RUN, evaluated in this priority order:
  1. memE & !DMemReadyE: StallF=StallD=StallE=1, FlushW=1. Next state MEM_WAIT, wait counter loaded with 1.
  2. PCSrcE: FlushD=1, FlushE=1, no stalls. Stays RUN.
  3. loaduse: StallF=StallD=1, FlushE=1 for exactly one cycle. Stays RUN. The load advances to W, so the dependent instruction is forwarded next cycle.
  4. Otherwise all Stall*/Flush* outputs are 0.
  - memE & DMemReadyE in the same cycle means zero wait. Rules 2 and 3 then apply as normal.
- MEM_WAIT:
  - DMemReadyE=1: all stalls 0 this cycle, the instruction advances. Next state RUN, counter cleared. loaduse and PCSrcE are evaluated as in RUN on this cycle.
  - DMemReadyE=0: StallF=StallD=StallE=1, FlushW=1, counter increments.
  - When the counter equals TIMEOUT_CYCLES-1 and DMemReadyE=0: next state FAULT.
- FAULT:
  - StallF=StallD=StallE=1 and FlushW=1 permanently.
  - MemTimeout=1 from the first FAULT cycle.
  - Exit only by reset. DMemReadyE is ignored.
- Forwarding (combinational, independent of state):
  - ForwardAE=01 iff RegWE_W_W & RdW!=0 & RdW==Rs1E; otherwise 00. ForwardBE uses Rs2E the same way.
  - Codes 10 and 11 are reserved, never driven.
- StallCount: +1 on each clk edge where StallF=1; saturates at all-ones with no wrap.
- Register x0 never creates a hazard or a forward.
- Reset mid MEM_WAIT: returns to RUN immediately; the pending access is abandoned.

Decomposition:
- Package c_hazard_pkg holds:
  - typedef enum hz_state_t {RUN, MEM_WAIT, FAULT};
  - constants EXP_ALU=2'b00, EXP_MEM=2'b01, EXP_LINK=2'b10;
  - constants FWD_RF=2'b00, FWD_W=2'b01.
- EXP_* are shared with the decoder and the ID/EX register.
- One sub-module, c_hazard_forward: the combinational forwarding compare, instantiated for operand A and operand B.

Test Plan:
- Load-use: ExPathE=01, RegWE_W_E=1, RdE=5, Rs1D=5 -> one cycle StallF=StallD=1, FlushE=1. Next cycle with RdW=5, Rs1E=5, RegWE_W_W=1 -> ForwardAE=01, no stall.
- x0 guard: RdE=0=Rs2D on a load; RdW=0=Rs1E -> no stall, ForwardAE=00.
- Branch: PCSrcE=1 with a simultaneous loaduse -> FlushD=FlushE=1, StallF=0.
- Memory wait: memE=1, DMemReadyE low 3 cycles then high -> StallF/D/E=1 and FlushW=1 for 3 cycles, released on the 4th, StallCount=3.
- Timeout: TIMEOUT_CYCLES=4, DMemReadyE held 0 -> FAULT entered after 4 stalled cycles, MemTimeout=1 sticky. Asserting reset -> all outputs 0, state RUN.
- Saturation: CNT_W=4, 20 stall cycles -> StallCount=15.
